jk_reg_bank: RTL
================

Name: jk_reg_bank

Overview:
- Parametrised, multi-bit successor to the single-bit JK flip-flop cell.
- WIDTH independent flip-flops with internal state feedback; no external q0 input.
- Selectable per-cycle mode: JK, D, T, SR, count up, count down, shift.
- Provides a change mask, a wrap-carry pulse and a sticky SR-conflict flag; used as a general state/control register in the lesson designs.

Parameters:
- WIDTH, 8, number of flip-flop bits (≥2).
- RST_VAL, {WIDTH{1'b0}}, value loaded into q on reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- en  input  1  update enable; 0 = hold all state (mask/carry still update, see below).
- mode  input  3  operation select, sampled at rising edge.
- j  input  WIDTH  per-bit J / S / T-enable / shift serial-in (bit 0).
- k  input  WIDTH  per-bit K / R.
- d  input  WIDTH  data for D mode.
- clr_err  input  1  synchronous clear of sr_err.
- q  output  WIDTH  register state.
- changed  output  WIDTH  registered mask, bit set where q changed on last edge.
- carry  output  1  one-cycle pulse on count wrap.
- sr_err  output  1  sticky flag, S=R=1 seen in SR mode.

Behaviour:
- Reset (rst=0, any time, asynchronous): q=RST_VAL, changed=0, carry=0, sr_err=0. Reset mid-operation aborts the current mode; the first update after rst rises starts from RST_VAL.
- Next-state q_n is computed combinationally from q; the edge registers q<=q_n, changed<=q^q_n, carry<=wrap. Latency is 1 clock for every mode.
- en=0: q_n=q, so changed=0 and carry=0 on that edge. sr_err still honours clr_err.
- Mode encoding (per bit i unless stated):
  - 000 HOLD: q_n=q.
  - 001 JK: 00 hold, 01 clear, 10 set, 11 toggle.
  - 010 D: q_n=d.
  - 011 T: q_n[i]=q[i]^j[i]; k ignored.
  - 100 SR: S=j, R=k. 10 set, 01 clear, 00 hold. 11 is illegal: hold that bit and set sr_err.
  - 101 COUNT_UP: q_n=q+1 mod 2^WIDTH. wrap=1 when q is all ones.
  - 110 COUNT_DN: q_n=q-1 mod 2^WIDTH. wrap=1 when q=0.
  - 111 SHIFT: q_n={q[WIDTH-2:0], j[0]}; j[WIDTH-1:1] and k ignored.
- wrap=0 in all non-count modes. Counting and shifting ignore j/k/d except as stated.
- sr_err sticky: set on an edge where en=1, mode=SR and any bit has j&k=1. Cleared on an edge where clr_err=1. If set and clear happen on the same edge, set wins.
- Mode may change every cycle; there is no internal mode state beyond q.
- All arithmetic is unsigned, WIDTH bits, truncating.

Test Plan:
- Reset/JK truth table (WIDTH=8): hold rst low 17 ns -> q=00, changed=00. JK mode, j=F0, k=0F from q=00 -> q=F0. Then j=k=FF -> q=0F, changed=FF. Then j=k=00 -> q=0F, changed=00.
- Count wrap: D mode load d=FE, then COUNT_UP 3 edges -> q=FF, 00, 01, with carry high only for the edge that produced 00. COUNT_DN from 01 -> 00, then FF with carry on the FF edge.
- SR conflict: q=00, SR mode, j=03, k=01 -> q=02, sr_err=1 and stays 1 through 5 HOLD cycles. clr_err=1 -> sr_err=0. Conflict together with clr_err on the same edge -> sr_err=1.
- Enable gating: COUNT_UP with en toggling 1,0,1 from q=10 -> q=11, 11, 12, and changed=00 on the en=0 edge.
- Shift/T: SHIFT with j[0]=1,0,1 from q=00 -> 01, 02, 05. T mode j=81 -> q=84.
- Async reset mid-count: assert rst between clock edges at q=37 -> q=RST_VAL immediately, with no wait for a clock edge. Release rst and COUNT_UP -> q=01 after the first edge.

Source files
------------

// File: rtl/jk_reg_bank_if.sv
// Bus bundle for jk_reg_bank: control/data inputs toward the bank, register
// state and status flags back from it.
interface jk_reg_bank_if #(
   parameter int WIDTH = 8
);
   logic             en;
   logic [2:0]       mode;
   logic [WIDTH-1:0] j;
   logic [WIDTH-1:0] k;
   logic [WIDTH-1:0] d;
   logic             clr_err;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] changed;
   logic             carry;
   logic             sr_err;

   modport master (
      output en, mode, j, k, d, clr_err,
      input  q, changed, carry, sr_err
   );

   modport slave (
      input  en, mode, j, k, d, clr_err,
      output q, changed, carry, sr_err
   );
endinterface

// File: rtl/jk_reg_bank.sv
// WIDTH-bit bank of feedback flip-flops with per-cycle mode select
// (JK, D, T, SR, count up/down, shift), change mask, wrap carry and SR-conflict flag.
module jk_reg_bank #(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
   input logic          clk,
   input logic          rst,
   jk_reg_bank_if.slave bus
);
   typedef enum logic [2:0] {
      MODE_HOLD  = 3'b000,
      MODE_JK    = 3'b001,
      MODE_D     = 3'b010,
      MODE_T     = 3'b011,
      MODE_SR    = 3'b100,
      MODE_UP    = 3'b101,
      MODE_DN    = 3'b110,
      MODE_SHIFT = 3'b111
   } mode_t;

   mode_t            mode_sel;
   logic [WIDTH-1:0] q_reg, q_next;
   logic [WIDTH-1:0] changed_reg;
   logic             carry_reg, carry_next;
   logic             sr_err_reg, sr_err_next;
   logic [WIDTH-1:0] jk_bit, sr_bit, conflict;
   logic             sr_set;

   assign mode_sel = mode_t'(bus.mode);

   // Per-bit characteristic equations; an SR conflict (11) holds the bit.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
         assign jk_bit[gi]   = (bus.j[gi] & ~q_reg[gi]) | (~bus.k[gi] & q_reg[gi]);
         assign sr_bit[gi]   = (bus.j[gi] & ~bus.k[gi]) | (q_reg[gi] & ~(bus.j[gi] ^ bus.k[gi]));
         assign conflict[gi] = bus.j[gi] & bus.k[gi];
      end
   endgenerate

   always_comb begin
      q_next     = q_reg;
      carry_next = 1'b0;
      if (bus.en) begin
         case (mode_sel)
            MODE_HOLD:  q_next = q_reg;
            MODE_JK:    q_next = jk_bit;
            MODE_D:     q_next = bus.d;
            MODE_T:     q_next = q_reg ^ bus.j;
            MODE_SR:    q_next = sr_bit;
            MODE_UP: begin
               q_next     = q_reg + WIDTH'(1);
               carry_next = &q_reg;
            end
            MODE_DN: begin
               q_next     = q_reg - WIDTH'(1);
               carry_next = ~|q_reg;
            end
            MODE_SHIFT: q_next = {q_reg[WIDTH-2:0], bus.j[0]};
            default:    q_next = q_reg;
         endcase
      end
   end

   // A conflict on the same edge as a clear keeps the flag set.
   assign sr_set      = bus.en && (mode_sel == MODE_SR) && (|conflict);
   assign sr_err_next = sr_set ? 1'b1 : (bus.clr_err ? 1'b0 : sr_err_reg);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_reg       <= RST_VAL;
         changed_reg <= '0;
         carry_reg   <= 1'b0;
         sr_err_reg  <= 1'b0;
      end else begin
         q_reg       <= q_next;
         changed_reg <= q_reg ^ q_next;
         carry_reg   <= carry_next;
         sr_err_reg  <= sr_err_next;
      end
   end

   assign bus.q       = q_reg;
   assign bus.changed = changed_reg;
   assign bus.carry   = carry_reg;
   assign bus.sr_err  = sr_err_reg;
endmodule
